// File: rtl/hv_job_seq.sv
// ---------------------------------------------------------------------------
// hv_job_seq
//
// Job sequencer for the hypervector encoder pipeline. A single start command
// walks the core through the item-memory write phase (matw / mat_a), a one
// cycle settle gap, and the compute phase (run). During compute it counts
// completed output packets (last beats on the master AXI-Stream) until the
// programmed job count is reached, then pulses done. A stall watchdog and an
// abort command can both terminate the job early.
//
// Ports
//   AXIS_ACLK, AXIS_ARESETN     clock, asynchronous active-low reset
//   start, abort                one-cycle command pulses
//   skip_matw                   bypass the item-memory write phase
//   cfg_item_num                last item-memory address (items - 1)
//   cfg_chunk, cfg_ngram        geometry, presented on addr_i / addr_j
//   cfg_jobs                    number of output packets - 1
//   cfg_timeout                 stall limit in RUN cycles, 0 disables
//   dst_valid/ready/last        taps of the master AXI-Stream handshake
//   matw, mat_a                 item-memory write enable and address
//   run                         compute enable
//   addr_i, addr_j              latched geometry
//   busy, done                  activity flag, one-cycle completion pulse
//   err, aborted                sticky timeout / abort flags
//   job_cnt                     packets completed in the current job
// ---------------------------------------------------------------------------
module hv_job_seq #(
   parameter int NUM_W  = 16,
   parameter int ADDR_W = 20,
   parameter int JOB_W  = 8
) (
   input  logic              AXIS_ACLK,
   input  logic              AXIS_ARESETN,
   input  logic              start,
   input  logic              abort,
   input  logic              skip_matw,
   input  logic [NUM_W-1:0]  cfg_item_num,
   input  logic [ADDR_W-1:0] cfg_chunk,
   input  logic [ADDR_W-1:0] cfg_ngram,
   input  logic [JOB_W-1:0]  cfg_jobs,
   input  logic [31:0]       cfg_timeout,
   input  logic              dst_valid,
   input  logic              dst_ready,
   input  logic              dst_last,
   output logic              matw,
   output logic [NUM_W-1:0]  mat_a,
   output logic              run,
   output logic [ADDR_W-1:0] addr_i,
   output logic [ADDR_W-1:0] addr_j,
   output logic              busy,
   output logic              done,
   output logic              err,
   output logic              aborted,
   output logic [JOB_W-1:0]  job_cnt
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_MATW,
      S_GAP,
      S_RUN,
      S_DONE
   } state_e;

   state_e              state_q, state_d;
   logic [NUM_W-1:0]    mat_a_q, mat_a_d;
   logic [NUM_W-1:0]    item_num_q, item_num_d;
   logic [ADDR_W-1:0]   addr_i_q, addr_i_d;
   logic [ADDR_W-1:0]   addr_j_q, addr_j_d;
   logic [JOB_W-1:0]    jobs_q, jobs_d;
   logic [JOB_W-1:0]    job_cnt_q, job_cnt_d;
   logic [31:0]         timeout_q, timeout_d;
   logic [31:0]         stall_q, stall_d;
   logic                err_q, err_d;
   logic                aborted_q, aborted_d;

   logic                beat;
   logic                last_beat;
   logic [32:0]         stall_inc;

   assign beat      = dst_valid & dst_ready;
   assign last_beat = beat & dst_last;
   // One bit wider so the threshold compare cannot wrap for huge limits.
   assign stall_inc = {1'b0, stall_q} + 33'd1;

   // NOTE: every signal assigned below gets a default first, so no path
   // through the case statement can leave one unassigned and infer a latch.
   always_comb begin
      state_d    = state_q;
      mat_a_d    = '0;
      item_num_d = item_num_q;
      addr_i_d   = addr_i_q;
      addr_j_d   = addr_j_q;
      jobs_d     = jobs_q;
      job_cnt_d  = job_cnt_q;
      timeout_d  = timeout_q;
      stall_d    = stall_q;
      err_d      = err_q;
      aborted_d  = aborted_q;

      case (state_q)
         S_IDLE: begin
            if (start && !abort) begin
               item_num_d = cfg_item_num;
               addr_i_d   = cfg_chunk;
               addr_j_d   = cfg_ngram;
               jobs_d     = cfg_jobs;
               timeout_d  = cfg_timeout;
               job_cnt_d  = '0;
               stall_d    = '0;
               err_d      = 1'b0;
               aborted_d  = 1'b0;
               state_d    = skip_matw ? S_GAP : S_MATW;
            end
         end
         S_MATW: begin
            // Address item_num is the last write; mat_a drops back to 0.
            if (mat_a_q == item_num_q) begin
               state_d = S_GAP;
            end else begin
               mat_a_d = mat_a_q + NUM_W'(1);
            end
         end
         S_GAP: begin
            state_d = S_RUN;
         end
         S_RUN: begin
            stall_d = beat ? '0 : stall_inc[31:0];
            if (last_beat) begin
               job_cnt_d = job_cnt_q + JOB_W'(1);
               if (job_cnt_q == jobs_q) begin
                  state_d = S_DONE;
               end
            end else if (!beat && (timeout_q != '0) &&
                         (stall_inc >= {1'b0, timeout_q})) begin
               // A beat in the threshold cycle is handled above and wins.
               err_d   = 1'b1;
               state_d = S_IDLE;
            end
         end
         S_DONE: begin
            state_d = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase

      // Abort outranks completion and timeout; a beat in the same cycle is
      // still counted, but the watchdog must not flag an error.
      if (abort && (state_q != S_IDLE)) begin
         state_d   = S_IDLE;
         mat_a_d   = '0;
         err_d     = err_q;
         aborted_d = 1'b1;
      end
   end

   // NOTE: state registers use non-blocking assignments so every flop
   // samples its next value from the same pre-edge snapshot.
   always_ff @(posedge AXIS_ACLK or negedge AXIS_ARESETN) begin
      if (!AXIS_ARESETN) begin
         state_q    <= S_IDLE;
         mat_a_q    <= '0;
         item_num_q <= '0;
         addr_i_q   <= '0;
         addr_j_q   <= '0;
         jobs_q     <= '0;
         job_cnt_q  <= '0;
         timeout_q  <= '0;
         stall_q    <= '0;
         err_q      <= 1'b0;
         aborted_q  <= 1'b0;
      end else begin
         state_q    <= state_d;
         mat_a_q    <= mat_a_d;
         item_num_q <= item_num_d;
         addr_i_q   <= addr_i_d;
         addr_j_q   <= addr_j_d;
         jobs_q     <= jobs_d;
         job_cnt_q  <= job_cnt_d;
         timeout_q  <= timeout_d;
         stall_q    <= stall_d;
         err_q      <= err_d;
         aborted_q  <= aborted_d;
      end
   end

   // Outputs decode registered state only, so reset clears them at once and
   // no input reaches an output without passing through a flop.
   assign matw    = (state_q == S_MATW);
   assign run     = (state_q == S_RUN);
   assign busy    = (state_q != S_IDLE);
   assign done    = (state_q == S_DONE);
   assign mat_a   = mat_a_q;
   assign addr_i  = addr_i_q;
   assign addr_j  = addr_j_q;
   assign err     = err_q;
   assign aborted = aborted_q;
   assign job_cnt = job_cnt_q;

endmodule
